// File: rtl/msj_pwm_driver.sv
// H-bridge PWM driver: clamps and slew-limits a signed duty command, applies it at
// period boundaries, and blanks both bridge lines for DEAD_TIME after a direction reversal.
module msj_pwm_driver #(
    parameter int PWM_PERIOD = 2500,
    parameter int DEAD_TIME  = 25
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [31:0] duty,
    input  logic               duty_valid,
    input  logic        [15:0] slew_step,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic               period_tick,
    output logic signed [31:0] applied_duty
);

    localparam int                 CW         = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CW-1:0]      LAST_COUNT = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0]      DEAD_LAST  = CW'(DEAD_TIME - 1);
    localparam logic signed [31:0] FULL_SCALE = 32'(PWM_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DEAD
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_counter;
    logic               r_period_tick;
    logic signed [31:0] r_target;
    logic signed [31:0] r_applied;
    logic               r_pwm_a;
    logic               r_pwm_b;

    logic               w_wrap;
    logic signed [31:0] w_duty_sat;
    logic signed [32:0] w_delta;
    logic signed [32:0] w_delta_mag;
    logic signed [32:0] w_step_wide;
    logic signed [31:0] w_step;
    logic               w_limit;
    logic signed [31:0] w_slewed;
    logic               w_reversal;
    logic signed [31:0] w_applied_next;
    logic signed [31:0] w_count_ext;
    logic               w_pwm_a_next;
    logic               w_pwm_b_next;

    assign w_wrap = (r_counter == LAST_COUNT);

    // The period counter free-runs regardless of enable so the tick keeps pacing the controller.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_counter     <= '0;
            r_period_tick <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_counter     <= w_wrap ? '0 : r_counter + CW'(1);
            r_period_tick <= w_wrap;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_duty_sat = duty;
        if (duty > FULL_SCALE) begin
            w_duty_sat = FULL_SCALE;
        end else if (duty < -FULL_SCALE) begin
            w_duty_sat = -FULL_SCALE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_target <= '0;
        end else if (duty_valid) begin
            r_target <= w_duty_sat;
        end
    end

    // Delta is formed one bit wider so target - applied can never overflow.
    always_comb begin
        w_delta     = $signed({r_target[31], r_target}) - $signed({r_applied[31], r_applied});
        w_delta_mag = w_delta[32] ? -w_delta : w_delta;
        w_step_wide = $signed({17'd0, slew_step});
        w_step      = $signed({16'd0, slew_step});
        w_limit     = (slew_step != 16'd0) && (w_delta_mag > w_step_wide);
        w_slewed    = r_target;
        if (w_limit) begin
            w_slewed = w_delta[32] ? (r_applied - w_step) : (r_applied + w_step);
        end
    end

    assign w_reversal = (r_applied != '0) && (w_slewed != '0) && (r_applied[31] != w_slewed[31]);

    // Next-state logic; applied duty moves only at a wrap, except that disable clears it at once.
    always_comb begin
        w_state_next   = r_state;
        w_applied_next = r_applied;
        if (!enable) begin
            w_state_next   = ST_IDLE;
            w_applied_next = '0;
        end else if (w_wrap) begin
            w_applied_next = w_slewed;
            w_state_next   = w_reversal ? ST_DEAD : ST_RUN;
        end else if ((r_state == ST_DEAD) && (r_counter == DEAD_LAST)) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_applied <= '0;
        end else begin
            r_state   <= w_state_next;
            r_applied <= w_applied_next;
        end
    end

    assign w_count_ext = $signed({{(32 - CW){1'b0}}, r_counter});

    // Only RUN drives the bridge, and the sign of applied selects a single line.
    always_comb begin
        w_pwm_a_next = 1'b0;
        w_pwm_b_next = 1'b0;
        if (r_state == ST_RUN) begin
            w_pwm_a_next = (r_applied > 0) && (w_count_ext < r_applied);
            w_pwm_b_next = (r_applied < 0) && (w_count_ext < -r_applied);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm_a <= 1'b0;
            r_pwm_b <= 1'b0;
        end else begin
            r_pwm_a <= w_pwm_a_next;
            r_pwm_b <= w_pwm_b_next;
        end
    end

    assign pwm_a        = r_pwm_a;
    assign pwm_b        = r_pwm_b;
    assign period_tick  = r_period_tick;
    assign applied_duty = r_applied;

endmodule

// File: tb/tb_msj_pwm_driver.sv
// Bench for msj_pwm_driver: a period-level model is compared every cycle, and
// hand-computed per-period pulse counts pin the model for each scenario.
module tb_msj_pwm_driver;

    localparam int P = 100;
    localparam int D = 5;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               enable;
    logic signed [31:0] duty;
    logic               duty_valid;
    logic        [15:0] slew_step;
    logic               pwm_a;
    logic               pwm_b;
    logic               period_tick;
    logic signed [31:0] applied_duty;

    int n_checks = 0;
    int n_errors = 0;

    msj_pwm_driver #(
        .PWM_PERIOD(P),
        .DEAD_TIME (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .slew_step   (slew_step),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .period_tick (period_tick),
        .applied_duty(applied_duty)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0b, expected %0b", name, actual, expected);
        end
    endtask

    // Model: position in the period comes from the cycle count; a reversal period blanks its first D slots.
    int   m_cyc;
    int   m_target;
    int   m_applied;
    bit   m_running;
    bit   m_reversed;
    logic e_pwm_a;
    logic e_pwm_b;
    logic e_tick;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cyc      = 0;
            m_target   = 0;
            m_applied  = 0;
            m_running  = 1'b0;
            m_reversed = 1'b0;
            e_pwm_a    = 1'b0;
            e_pwm_b    = 1'b0;
            e_tick     = 1'b0;
        end else begin : model_step
            int c;
            int nxt;
            int step;
            c       = m_cyc % P;
            step    = int'(slew_step);
            e_pwm_a = m_running && !(m_reversed && c < D) && m_applied > 0 && c < m_applied;
            e_pwm_b = m_running && !(m_reversed && c < D) && m_applied < 0 && c < -m_applied;
            e_tick  = (c == P - 1);
            if (!enable) begin
                m_running  = 1'b0;
                m_applied  = 0;
                m_reversed = 1'b0;
            end else if (c == P - 1) begin
                nxt = m_target;
                if (step != 0 && m_target - m_applied > step) nxt = m_applied + step;
                if (step != 0 && m_applied - m_target > step) nxt = m_applied - step;
                m_reversed = (m_applied * nxt) < 0;
                m_applied  = nxt;
                m_running  = 1'b1;
            end
            if (duty_valid) m_target = (duty > P) ? P : (duty < -P) ? -P : int'(duty);
            m_cyc++;
        end
    end

    always @(negedge clock) begin
        check_bit("pwm_a", pwm_a, e_pwm_a);
        check_bit("pwm_b", pwm_b, e_pwm_b);
        check_bit("period_tick", period_tick, e_tick);
        check("applied_duty", applied_duty, m_applied);
        check_bit("a_b_exclusive", pwm_a & pwm_b, 1'b0);
    end

    function automatic int phase();
        return m_cyc % P;
    endfunction

    task automatic wait_phase(input int k);
        for (int i = 0; i <= P; i++) begin
            @(negedge clock);
            if (phase() == k) return;
        end
        check("wait_phase", phase(), k);
    endtask

    task automatic strobe(input int v);
        @(negedge clock);
        duty       = v;
        duty_valid = 1'b1;
        @(negedge clock);
        duty_valid = 1'b0;
    endtask

    // Counts one full period window (counter 0..P-1) and checks it against literal values.
    task automatic expect_period(input string tag, input int ea, input int eb,
                                 input int efb, input int eapp);
        int na, nb, first_b, ticks, tick_at, app;
        na = 0; nb = 0; first_b = -1; ticks = 0; tick_at = -1;
        wait_phase(0);
        app = applied_duty;
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clock);
            if (pwm_a) na++;
            if (pwm_b) begin
                nb++;
                if (first_b < 0) first_b = i;
            end
            if (period_tick) begin
                ticks++;
                if (tick_at < 0) tick_at = i;
            end
        end
        check({tag, "_high_a"}, na, ea);
        check({tag, "_high_b"}, nb, eb);
        check({tag, "_applied"}, app, eapp);
        check({tag, "_ticks"}, ticks, 1);
        check({tag, "_tick_pos"}, tick_at, 0);
        if (efb >= 0) check({tag, "_first_b"}, first_b, efb);
    endtask

    initial begin
        enable     = 1'b0;
        duty       = '0;
        duty_valid = 1'b0;
        slew_step  = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check_bit("rst_pwm_a", pwm_a, 1'b0);
        check_bit("rst_pwm_b", pwm_b, 1'b0);
        check_bit("rst_tick", period_tick, 1'b0);
        check("rst_applied", applied_duty, 0);
        reset = 1'b0;

        // Plain 40% duty
        enable = 1'b1;
        strobe(40);
        expect_period("t1_first", 40, 0, -1, 40);
        expect_period("t1_steady", 40, 0, -1, 40);

        // Saturation both ways, full-scale and reversal at full scale
        strobe(250);
        expect_period("t2_up", 99, 0, -1, 100);
        expect_period("t2_full", 100, 0, -1, 100);
        strobe(-250);
        expect_period("t2_rev", 1, 94, 6, -100);
        expect_period("t2_full_neg", 0, 100, -1, -100);

        // Slew ramp 0 -> 35
        strobe(0);
        expect_period("t3_zero", 0, 1, 0, 0);
        strobe(35);
        slew_step = 16'd10;
        expect_period("t3_r10", 10, 0, -1, 10);
        expect_period("t3_r20", 20, 0, -1, 20);
        expect_period("t3_r30", 30, 0, -1, 30);
        expect_period("t3_r35", 35, 0, -1, 35);

        // Reversal +40 -> -40 with dead time
        slew_step = 16'd0;
        strobe(40);
        expect_period("t4_pos", 40, 0, -1, 40);
        strobe(-40);
        expect_period("t4_rev", 0, 35, 6, -40);
        expect_period("t4_neg", 0, 40, 1, -40);

        // Capture on the wrap cycle is deferred by one period
        strobe(20);
        expect_period("t5_pre", 15, 0, -1, 20);
        duty       = 60;
        duty_valid = 1'b1;
        @(negedge clock);
        duty_valid = 1'b0;
        check("t5_same_wrap", applied_duty, 20);
        wait_phase(0);
        check("t5_next_wrap", applied_duty, 60);

        // Disable mid-pulse, then re-enable under slew
        strobe(40);
        expect_period("t6_pos", 40, 0, -1, 40);
        wait_phase(10);
        enable = 1'b0;
        @(negedge clock);
        check("t6_off_applied", applied_duty, 0);
        check_bit("t6_off_lag", pwm_a, 1'b1);
        @(negedge clock);
        check_bit("t6_off_pwm_a", pwm_a, 1'b0);
        slew_step = 16'd10;
        enable    = 1'b1;
        expect_period("t6_ramp10", 10, 0, -1, 10);
        expect_period("t6_ramp20", 20, 0, -1, 20);

        // Asynchronous reset in the middle of a pulse
        wait_phase(5);
        check_bit("t6_pre_reset", pwm_a, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit("t6_rst_pwm_a", pwm_a, 1'b0);
        check_bit("t6_rst_tick", period_tick, 1'b0);
        check("t6_rst_applied", applied_duty, 0);
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        slew_step = 16'd0;
        strobe(30);
        expect_period("t6_after_rst", 30, 0, -1, 30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/msj_pwm_driver.md
Name: msj_pwm_driver

Overview:
- Downstream stage of the MSJ platform PD controller. Consumes the signed per-motor duty word and drives one H-bridge with two complementary-direction PWM lines.
- Clamps and slew-limits the commanded duty, applies it only at PWM period boundaries, and inserts dead time on direction reversal.
- Emits a period tick that can drive the controller's update_controller input.

Parameters:
PWM_PERIOD, 2500, PWM period in clock cycles (20 kHz at 50 MHz); also the full-scale duty magnitude; must be >= 2
DEAD_TIME, 25, cycles with both outputs low after a direction reversal; must satisfy 1 <= DEAD_TIME < PWM_PERIOD

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  bridge enable; low forces outputs off and applied duty to 0
duty  input  32  signed duty command (PD controller output)
duty_valid  input  1  single-cycle strobe; captures duty
slew_step  input  16  unsigned max change of applied duty per period; 0 = unlimited
pwm_a  output  1  forward bridge input, registered
pwm_b  output  1  reverse bridge input, registered
period_tick  output  1  one-cycle pulse on the cycle the period counter wraps
applied_duty  output  32  signed duty currently in effect, for readback

Behaviour:
- Reset (async): counter=0, target=0, applied_duty=0, state=IDLE, pwm_a=pwm_b=0, period_tick=0.
- Counter:
  - Runs 0..PWM_PERIOD-1 continuously, independent of enable.
  - Wrap = the cycle where counter==PWM_PERIOD-1; next cycle counter=0.
  - period_tick is registered: high for exactly the cycle in which counter==0.
- Capture:
  - On duty_valid, target <= duty saturated to [-PWM_PERIOD, +PWM_PERIOD].
  - A capture on the wrap cycle is not seen by that wrap; it takes effect at the following wrap.
- Update at wrap (only when enable=1):
  - delta = target - applied, computed in 33-bit signed.
  - If slew_step!=0 and |delta|>slew_step: applied <= applied + sign(delta)*slew_step.
  - Otherwise: applied <= target.
- Reversal: at a wrap where old applied and new applied are both nonzero with opposite signs, state <= DEAD; otherwise state <= RUN.
- States:
  - IDLE: entered on reset or enable=0. Outputs low, applied=0. Leaves to RUN at the first wrap with enable=1.
  - RUN: normal PWM.
  - DEAD: both outputs low while counter < DEAD_TIME. Returns to RUN on the cycle after counter==DEAD_TIME-1. Normal PWM then continues for the rest of the period.
- Output function (evaluated from registered counter/state/applied, registered once; one clock of latency relative to counter):
  - pwm_a = (state==RUN) && applied>0 && counter < applied
  - pwm_b = (state==RUN) && applied<0 && counter < -applied
  - Consequences: applied=0 gives both low; |applied|=PWM_PERIOD gives the active line high all period.
  - pwm_a and pwm_b are never simultaneously high, under any input sequence.
- enable deassert:
  - Takes effect mid-period: the next cycle the state is IDLE and applied=0, so pwm lines go low the cycle after.
  - target is retained.
  - Re-enable ramps from 0 under slew_step.
- slew_step change takes effect at the next wrap.
- Reset mid-period: all outputs low immediately; the counter restarts at 0 after release.

Test Plan:
All scenarios use PWM_PERIOD=100, DEAD_TIME=5.
1. enable=1, slew_step=0, duty=40 strobed -> from the period after the next wrap: pwm_a high 40 of every 100 cycles, pwm_b low, applied_duty=40, period_tick every 100 cycles.
2. duty=250 then duty=-250 -> applied_duty=100 with pwm_a constantly high; then applied_duty=-100 with pwm_b high except the first 5 cycles of the reversal period.
3. slew_step=10, applied 0, duty=35 -> applied_duty 10, 20, 30, 35 on consecutive wraps; pulse widths 10, 20, 30, 35.
4. applied 40, duty=-40, slew_step=0 -> reversal period: pwm_a low all period, pwm_b low for counter 0..4 and high for 5..39; following periods pwm_b high for 0..39; pwm_a&pwm_b never 1 (assertion runs all tests).
5. Strobe duty=60 exactly on a wrap cycle while target=20 -> that wrap applies 20, the next wrap applies 60.
6. enable dropped at counter=10 during a 40 pulse -> pwm_a low within 2 cycles, applied_duty=0; re-enable with slew_step=10 -> ramps 10, 20, ...; async reset asserted mid-pulse -> pwm_a=0, period_tick=0, applied_duty=0 without a clock edge.
